// File: rtl/iq_scheduler.sv
// Wakeup/select issue queue feeding a single functional unit.
// Entries wait on two source tags, the oldest ready entry is staged in a valid/ready issue register.
module iq_scheduler #(
    parameter  int IQ_SIZE   = 16,
    parameter  int ROB_COUNT = 32,
    parameter  int PAYLOAD_W = 64,
    localparam int RW        = $clog2(ROB_COUNT),
    localparam int CW        = $clog2(IQ_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic [PAYLOAD_W-1:0] alloc_payload_i,
    input  logic [RW-1:0]        alloc_dest_ptr_i,
    input  logic                 alloc_src0_pending_i,
    input  logic [RW-1:0]        alloc_src0_ptr_i,
    input  logic                 alloc_src1_pending_i,
    input  logic [RW-1:0]        alloc_src1_ptr_i,
    input  logic                 wb_valid_i,
    input  logic [RW-1:0]        wb_rob_ptr_i,
    input  logic                 flush_i,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [PAYLOAD_W-1:0] issue_payload_o,
    output logic [RW-1:0]        issue_dest_ptr_o,
    output logic [CW-1:0]        count_o
);

    localparam int            IW   = $clog2(IQ_SIZE);
    localparam logic [CW-1:0] FULL = CW'(IQ_SIZE);

    logic [IQ_SIZE-1:0]   valid_q;
    logic [IQ_SIZE-1:0]   src0_pend_q;
    logic [IQ_SIZE-1:0]   src1_pend_q;
    logic [PAYLOAD_W-1:0] payload_q  [IQ_SIZE];
    logic [RW-1:0]        dest_q     [IQ_SIZE];
    logic [RW-1:0]        src0_ptr_q [IQ_SIZE];
    logic [RW-1:0]        src1_ptr_q [IQ_SIZE];
    // older_q[i][j] set means entry i was allocated before entry j
    logic [IQ_SIZE-1:0]   older_q    [IQ_SIZE];
    logic [CW-1:0]        count_q;

    logic                 issue_valid_q;
    logic [PAYLOAD_W-1:0] issue_payload_q;
    logic [RW-1:0]        issue_dest_q;

    logic [IQ_SIZE-1:0]   ready;
    logic [IQ_SIZE-1:0]   grant;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        free_idx;
    logic                 alloc_fire;
    logic                 issue_fire;
    logic                 bypass0;
    logic                 bypass1;

    assign ready = valid_q & ~src0_pend_q & ~src1_pend_q;

    always_comb begin
        grant = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < IQ_SIZE; j++) begin
                if (ready[j] && older_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    // Descending scan so the lowest free index is the one that sticks
    always_comb begin
        free_idx = '0;
        for (int i = IQ_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign alloc_ready_o = (count_q < FULL);
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign issue_fire    = (!issue_valid_q || issue_ready_i) && (|ready);
    assign bypass0       = wb_valid_i && (alloc_src0_ptr_i == wb_rob_ptr_i);
    assign bypass1       = wb_valid_i && (alloc_src1_ptr_i == wb_rob_ptr_i);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q         <= '0;
            src0_pend_q     <= '0;
            src1_pend_q     <= '0;
            count_q         <= '0;
            issue_valid_q   <= 1'b0;
            issue_payload_q <= '0;
            issue_dest_q    <= '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            if (wb_valid_i) begin
                for (int i = 0; i < IQ_SIZE; i++) begin
                    if (valid_q[i] && (src0_ptr_q[i] == wb_rob_ptr_i)) begin
                        src0_pend_q[i] <= 1'b0;
                    end
                    if (valid_q[i] && (src1_ptr_q[i] == wb_rob_ptr_i)) begin
                        src1_pend_q[i] <= 1'b0;
                    end
                end
            end

            if (issue_fire) begin
                valid_q[grant_idx] <= 1'b0;
                issue_valid_q      <= 1'b1;
                issue_payload_q    <= payload_q[grant_idx];
                issue_dest_q       <= dest_q[grant_idx];
            end else if (issue_ready_i) begin
                issue_valid_q <= 1'b0;
            end

            // The free slot is never valid, so it cannot collide with the wakeup or grant writes above
            if (alloc_fire) begin
                valid_q[free_idx]     <= 1'b1;
                src0_pend_q[free_idx] <= alloc_src0_pending_i && !bypass0;
                src1_pend_q[free_idx] <= alloc_src1_pending_i && !bypass1;
                older_q[free_idx]     <= '0;
                for (int j = 0; j < IQ_SIZE; j++) begin
                    older_q[j][free_idx] <= valid_q[j];
                end
            end

            count_q <= count_q + CW'(alloc_fire) - CW'(issue_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            payload_q[free_idx]  <= alloc_payload_i;
            dest_q[free_idx]     <= alloc_dest_ptr_i;
            src0_ptr_q[free_idx] <= alloc_src0_ptr_i;
            src1_ptr_q[free_idx] <= alloc_src1_ptr_i;
        end
    end

    assign issue_valid_o    = issue_valid_q;
    assign issue_payload_o  = issue_payload_q;
    assign issue_dest_ptr_o = issue_dest_q;
    assign count_o          = count_q;

endmodule

// File: tb/tb_iq_scheduler.sv
// Directed scenario bench for iq_scheduler: reset, latency, age order, full queue,
// backpressure, same-cycle wakeup bypass and flush.
module tb_iq_scheduler;

    localparam int IQ_SIZE   = 16;
    localparam int ROB_COUNT = 32;
    localparam int PAYLOAD_W = 64;
    localparam int RW        = $clog2(ROB_COUNT);
    localparam int CW        = $clog2(IQ_SIZE) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [PAYLOAD_W-1:0] alloc_payload;
    logic [RW-1:0]        alloc_dest;
    logic                 src0_pend;
    logic [RW-1:0]        src0_ptr;
    logic                 src1_pend;
    logic [RW-1:0]        src1_ptr;
    logic                 wb_valid;
    logic [RW-1:0]        wb_ptr;
    logic                 flush;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [RW-1:0]        issue_dest;
    logic [CW-1:0]        count;

    int total = 0;
    int bad   = 0;

    iq_scheduler #(
        .IQ_SIZE   (IQ_SIZE),
        .ROB_COUNT (ROB_COUNT),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .alloc_valid_i        (alloc_valid),
        .alloc_ready_o        (alloc_ready),
        .alloc_payload_i      (alloc_payload),
        .alloc_dest_ptr_i     (alloc_dest),
        .alloc_src0_pending_i (src0_pend),
        .alloc_src0_ptr_i     (src0_ptr),
        .alloc_src1_pending_i (src1_pend),
        .alloc_src1_ptr_i     (src1_ptr),
        .wb_valid_i           (wb_valid),
        .wb_rob_ptr_i         (wb_ptr),
        .flush_i              (flush),
        .issue_valid_o        (issue_valid),
        .issue_ready_i        (issue_ready),
        .issue_payload_o      (issue_payload),
        .issue_dest_ptr_o     (issue_dest),
        .count_o              (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid   = 1'b0;
        alloc_payload = '0;
        alloc_dest    = '0;
        src0_pend     = 1'b0;
        src0_ptr      = '0;
        src1_pend     = 1'b0;
        src1_ptr      = '0;
        wb_valid      = 1'b0;
        wb_ptr        = '0;
        flush         = 1'b0;
    endtask

    task automatic set_alloc(input logic [RW-1:0] dest, input logic [PAYLOAD_W-1:0] pl,
                             input logic p0, input logic [RW-1:0] ptr0,
                             input logic p1, input logic [RW-1:0] ptr1);
        alloc_valid   = 1'b1;
        alloc_dest    = dest;
        alloc_payload = pl;
        src0_pend     = p0;
        src0_ptr      = ptr0;
        src1_pend     = p1;
        src1_ptr      = ptr1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_ready = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", issue_valid); end
        total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b want=1", alloc_ready); end
        total++; if (issue_dest !== 5'd0 || issue_payload !== 64'd0) begin bad++; $display("[TB] FAIL reset_data got=%0d/%0h want=0/0", issue_dest, issue_payload); end
    endtask

    task automatic test_latency();
        issue_ready = 1'b1;
        set_alloc(5'd5, 64'hA5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clear_inputs();
        total++; if (count !== 5'd1 || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_e1 got count=%0d valid=%0b want 1/0", count, issue_valid); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_dest !== 5'd5) begin bad++; $display("[TB] FAIL lat_e2 got valid=%0b dest=%0d want 1/5", issue_valid, issue_dest); end
        total++; if (issue_payload !== 64'hA5A5 || count !== 5'd0) begin bad++; $display("[TB] FAIL lat_e2_data got pl=%0h count=%0d want a5a5/0", issue_payload, count); end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_drain got=%0b want=0", issue_valid); end
    endtask

    task automatic test_age_order();
        issue_ready = 1'b1;
        set_alloc(5'd1, 64'h1, 1'b1, 5'd7, 1'b0, 5'd0);
        tick();
        set_alloc(5'd2, 64'h2, 1'b0, 5'd0, 1'b1, 5'd7);
        tick();
        set_alloc(5'd3, 64'h3, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clear_inputs();
        total++; if (count !== 5'd3) begin bad++; $display("[TB] FAIL age_count got=%0d want=3", count); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_dest !== 5'd3) begin bad++; $display("[TB] FAIL age_c_first got valid=%0b dest=%0d want 1/3", issue_valid, issue_dest); end
        wb_valid = 1'b1;
        wb_ptr   = 5'd7;
        tick();
        clear_inputs();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL age_gap got=%0b want=0", issue_valid); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_dest !== 5'd1) begin bad++; $display("[TB] FAIL age_a got valid=%0b dest=%0d want 1/1", issue_valid, issue_dest); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_dest !== 5'd2 || count !== 5'd0) begin bad++; $display("[TB] FAIL age_b got valid=%0b dest=%0d count=%0d want 1/2/0", issue_valid, issue_dest, count); end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL age_drain got=%0b want=0", issue_valid); end
    endtask

    task automatic test_full();
        issue_ready = 1'b1;
        for (int k = 0; k < IQ_SIZE; k++) begin
            set_alloc(5'(k), 64'(100 + k), 1'b1, 5'd3, 1'b0, 5'd0);
            tick();
        end
        total++; if (count !== 5'd16 || alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_state got count=%0d ready=%0b want 16/0", count, alloc_ready); end
        set_alloc(5'd31, 64'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clear_inputs();
        total++; if (count !== 5'd16) begin bad++; $display("[TB] FAIL full_17th got count=%0d want=16", count); end
        wb_valid = 1'b1;
        wb_ptr   = 5'd3;
        tick();
        clear_inputs();
        total++; if (issue_valid !== 1'b0 || alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_wake got valid=%0b ready=%0b want 0/0", issue_valid, alloc_ready); end
        for (int k = 0; k < IQ_SIZE; k++) begin
            tick();
            total++;
            if (issue_valid !== 1'b1 || issue_dest !== 5'(k) || issue_payload !== 64'(100 + k)
                || count !== 5'(15 - k) || alloc_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL full_issue%0d got valid=%0b dest=%0d pl=%0d count=%0d ready=%0b want 1/%0d/%0d/%0d/1",
                         k, issue_valid, issue_dest, issue_payload, count, alloc_ready, k, 100 + k, 15 - k);
            end
        end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_drain got=%0b want=0", issue_valid); end
    endtask

    task automatic test_backpressure();
        issue_ready = 1'b0;
        set_alloc(5'd9, 64'h99, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_alloc(5'd10, 64'h1010, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (issue_valid !== 1'b1 || issue_dest !== 5'd9 || issue_payload !== 64'h99 || count !== 5'd1) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d got valid=%0b dest=%0d pl=%0h count=%0d want 1/9/99/1",
                         k, issue_valid, issue_dest, issue_payload, count);
            end
            tick();
        end
        total++; if (issue_valid !== 1'b1 || issue_dest !== 5'd9) begin bad++; $display("[TB] FAIL bp_hold_end got valid=%0b dest=%0d want 1/9", issue_valid, issue_dest); end
        issue_ready = 1'b1;
        tick();
        total++; if (issue_valid !== 1'b1 || issue_dest !== 5'd10 || count !== 5'd0) begin bad++; $display("[TB] FAIL bp_next got valid=%0b dest=%0d count=%0d want 1/10/0", issue_valid, issue_dest, count); end
        tick();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0b want=0", issue_valid); end
    endtask

    task automatic test_bypass_flush();
        issue_ready = 1'b1;
        set_alloc(5'd12, 64'hC, 1'b1, 5'd4, 1'b0, 5'd0);
        wb_valid = 1'b1;
        wb_ptr   = 5'd4;
        tick();
        clear_inputs();
        total++; if (count !== 5'd1) begin bad++; $display("[TB] FAIL byp_count got=%0d want=1", count); end
        tick();
        total++; if (issue_valid !== 1'b1 || issue_dest !== 5'd12) begin bad++; $display("[TB] FAIL byp_issue got valid=%0b dest=%0d want 1/12", issue_valid, issue_dest); end
        tick();

        issue_ready = 1'b0;
        set_alloc(5'd20, 64'h20, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        for (int k = 21; k <= 24; k++) begin
            set_alloc(5'(k), 64'(k), 1'b1, 5'd6, 1'b0, 5'd0);
            tick();
        end
        clear_inputs();
        total++; if (count !== 5'd4 || issue_valid !== 1'b1 || issue_dest !== 5'd20) begin bad++; $display("[TB] FAIL fl_pre got count=%0d valid=%0b dest=%0d want 4/1/20", count, issue_valid, issue_dest); end
        flush = 1'b1;
        set_alloc(5'd25, 64'h25, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clear_inputs();
        total++; if (count !== 5'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL fl_post got count=%0d valid=%0b ready=%0b want 0/0/1", count, issue_valid, alloc_ready); end
        total++; if (issue_dest !== 5'd0) begin bad++; $display("[TB] FAIL fl_dest got=%0d want=0", issue_dest); end
        issue_ready = 1'b1;
        wb_valid    = 1'b1;
        wb_ptr      = 5'd6;
        tick();
        clear_inputs();
        tick();
        total++; if (issue_valid !== 1'b0 || count !== 5'd0) begin bad++; $display("[TB] FAIL fl_empty got valid=%0b count=%0d want 0/0", issue_valid, count); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_age_order();
        test_full();
        test_backpressure();
        test_bypass_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
